// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with valid/ready handshake.
// Two-entry skid buffer (main + skid register) with a registered in_ready.
// Synchronous flush drops every held entry and injects a NOP bubble.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the saturating stall_cnt port.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 12,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                accept;
  logic                pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Next-state and storage update; flush overrides any accept/pop this cycle.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = NOP_CTRL;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (pop) begin
            // Bubble: never leave a stale control word visible while idle.
            state_d     = EMPTY;
            main_ctrl_d = NOP_CTRL;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = NOP_CTRL;
          main_data_d = '0;
        end
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State, handshake flags and payload registers; async active-low reset.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= NOP_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count cycles where upstream offers an entry but the buffer is full.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready_q) stall_cnt_d = sat_inc16(stall_cnt_q);
  end

  // Counter register; cleared by reset only, flush leaves it alone.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vectors, scoreboard queue
// filled by the driver on accept and drained by an independent monitor on pop.
module tb_pipe_stage_buf;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 12;
  localparam logic [CTRL_W-1:0] NOP = 12'hF00;

  logic              clk_50MHz = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop must match the oldest accepted, non-flushed entry.
  always @(negedge clk_50MHz) begin
    ent_t e;
    if (rst && out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_underflow actual=%0h required=no_entry", out_data);
      end else begin
        e = q.pop_front();
        chk("pop_ctrl", 64'(out_ctrl), 64'(e.c));
        chk("pop_data", out_data, e.d);
        pops++;
      end
    end
  end

  // One clock: apply inputs, log accept/flush before the edge, return 1ns after it.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy, input logic fl);
    ent_t e;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk_50MHz);
    if (fl) q.delete();
    else if (in_valid && in_ready) begin
      e.c = in_ctrl;
      e.d = in_data;
      q.push_back(e);
    end
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_occ"},       64'(occupancy), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_ctrl"},  64'(out_ctrl),  64'(NOP));
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  initial begin
    int p0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk_50MHz);
    #1;
    check_idle("reset");
    chk("reset_out_data", out_data, 64'd0);
    @(negedge clk_50MHz);
    rst = 1'b1;
    @(posedge clk_50MHz);
    #1;

    // Stream 1..8 with out_ready high: latency 1, one word per cycle.
    p0 = pops;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, CTRL_W'(12'h100 + i), DATA_W'(i), 1'b1, 1'b0);
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", out_data, 64'(i));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_idle("stream_end");
    chk("stream_pops", 64'(pops - p0), 64'd8);

    // Backpressure: A, B held, C refused, then drain in order.
    step(1'b1, 12'h0A1, 64'hAAAA_0000_0000_000A, 1'b0, 1'b0);
    step(1'b1, 12'h0B2, 64'hBBBB_0000_0000_000B, 1'b0, 1'b0);
    chk("bp_occ_full", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head", out_data, 64'hAAAA_0000_0000_000A);
    step(1'b1, 12'h0C3, 64'hCCCC_0000_0000_000C, 1'b0, 1'b0);
    chk("bp_stall_data", out_data, 64'hAAAA_0000_0000_000A);
    chk("bp_stall_ctrl", 64'(out_ctrl), 64'h0A1);
    chk("bp_stall_occ", 64'(occupancy), 64'd2);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("bp_occ_one", 64'(occupancy), 64'd1);
    chk("bp_second", out_data, 64'hBBBB_0000_0000_000B);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_idle("bp_end");

    // Flush while full with a new entry offered: everything dropped.
    step(1'b1, 12'h0D4, 64'hD, 1'b0, 1'b0);
    step(1'b1, 12'h0E5, 64'hE, 1'b0, 1'b0);
    chk("fl_occ_full", 64'(occupancy), 64'd2);
    step(1'b1, 12'h0C6, 64'hC, 1'b1, 1'b1);
    check_idle("flush");
    chk("flush_out_data", out_data, 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_idle("flush_after");

    // Simultaneous accept and pop at occupancy 1.
    step(1'b1, 12'h011, 64'h1111, 1'b0, 1'b0);
    chk("sim_occ_one", 64'(occupancy), 64'd1);
    step(1'b1, 12'h022, 64'h2222, 1'b1, 1'b0);
    chk("sim_occ", 64'(occupancy), 64'd1);
    chk("sim_data", out_data, 64'h2222);
    chk("sim_ctrl", 64'(out_ctrl), 64'h022);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_idle("sim_end");

    // Async reset mid-traffic: outputs return at once, no clock needed.
    step(1'b1, 12'h033, 64'h3333, 1'b0, 1'b0);
    step(1'b1, 12'h044, 64'h4444, 1'b0, 1'b0);
    chk("ar_occ_full", 64'(occupancy), 64'd2);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_idle("async_reset");
    chk("async_reset_data", out_data, 64'd0);
    q.delete();
    #2 rst = 1'b1;
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_idle("ar_after");

`ifdef PIPE_STAGE_PERF_EN
    chk("perf_reset", 64'(stall_cnt), 64'd0);
    step(1'b1, 12'h055, 64'h5, 1'b0, 1'b0);
    step(1'b1, 12'h066, 64'h6, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b1, 12'h077, 64'h7, 1'b0, 1'b0);
    chk("perf_sat", 64'(stall_cnt), 64'hFFFF);
    step(1'b1, 12'h077, 64'h7, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("perf_flush_keeps", 64'(stall_cnt), 64'hFFFF);
`endif

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
